// File: rtl/unidade_controle_jogo_seq_if.sv
// Control/status bundle between the memory-game control unit and its datapath/pins.
// slave = control unit side, master = datapath/top-level side.
interface unidade_controle_jogo_seq_if;
    logic       jogar;
    logic       jogada;
    logic       igual;
    logic       fim_jogada;
    logic       fim_rodada;
    logic       zera_rodada;
    logic       conta_rodada;
    logic       zera_jogada;
    logic       conta_jogada;
    logic       registra;
    logic       zera_reg;
    logic       pronto;
    logic       ganhou;
    logic       perdeu;
    logic       db_timeout;
    logic [3:0] db_estado;

    modport master (
        output jogar, jogada, igual, fim_jogada, fim_rodada,
        input  zera_rodada, conta_rodada, zera_jogada, conta_jogada, registra, zera_reg,
        input  pronto, ganhou, perdeu, db_timeout, db_estado
    );

    modport slave (
        input  jogar, jogada, igual, fim_jogada, fim_rodada,
        output zera_rodada, conta_rodada, zera_jogada, conta_jogada, registra, zera_reg,
        output pronto, ganhou, perdeu, db_timeout, db_estado
    );
endinterface

// File: rtl/unidade_controle_jogo_seq.sv
// Moore control unit for the memory game: sequences rounds/plays, owns the play
// timeout timer and flags win, wrong-play loss or timeout loss.
module unidade_controle_jogo_seq #(
    parameter int unsigned TIMEOUT_CYCLES = 5000,
    parameter int unsigned TW             = 13
) (
    input logic                        clock,
    input logic                        reset,
    unidade_controle_jogo_seq_if.slave ctl
);

    typedef enum logic [3:0] {
        INICIAL       = 4'h0,
        PREPARA       = 4'h1,
        INICIA_RODADA = 4'h2,
        ESPERA        = 4'h3,
        REGISTRA      = 4'h4,
        COMPARA       = 4'h5,
        PROX_JOGADA   = 4'h6,
        PROX_RODADA   = 4'h7,
        FIM_GANHOU    = 4'hA,
        FIM_ERROU     = 4'hE,
        FIM_TIMEOUT   = 4'hF
    } t_estado;

    localparam logic [TW-1:0] LP_TMAX = TW'(TIMEOUT_CYCLES - 1);

    t_estado       r_estado;
    t_estado       w_prox;
    logic [TW-1:0] r_timer;
    logic          w_expirou;

    assign w_expirou = (r_timer == LP_TMAX);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_estado <= INICIAL;
        end else begin
            r_estado <= w_prox;
        end
    end

    // Held at zero outside ESPERA, so every entry to ESPERA starts from zero.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_timer <= '0;
        end else if (r_estado == ESPERA) begin
            if (r_timer != '1) begin
                r_timer <= r_timer + TW'(1);
            end
        end else begin
            r_timer <= '0;
        end
    end

    always_comb begin
        w_prox           = r_estado;
        ctl.zera_rodada  = 1'b0;
        ctl.conta_rodada = 1'b0;
        ctl.zera_jogada  = 1'b0;
        ctl.conta_jogada = 1'b0;
        ctl.registra     = 1'b0;
        ctl.zera_reg     = 1'b0;
        ctl.pronto       = 1'b0;
        ctl.ganhou       = 1'b0;
        ctl.perdeu       = 1'b0;
        ctl.db_timeout   = 1'b0;

        case (r_estado)
            INICIAL: begin
                if (ctl.jogar) w_prox = PREPARA;
            end
            PREPARA: begin
                ctl.zera_rodada = 1'b1;
                ctl.zera_jogada = 1'b1;
                ctl.zera_reg    = 1'b1;
                w_prox          = INICIA_RODADA;
            end
            INICIA_RODADA: begin
                ctl.zera_jogada = 1'b1;
                w_prox          = ESPERA;
            end
            ESPERA: begin
                // A press in the expiry cycle still counts as a play.
                if (ctl.jogada)     w_prox = REGISTRA;
                else if (w_expirou) w_prox = FIM_TIMEOUT;
            end
            REGISTRA: begin
                ctl.registra = 1'b1;
                w_prox       = COMPARA;
            end
            COMPARA: begin
                if (!ctl.igual)           w_prox = FIM_ERROU;
                else if (!ctl.fim_jogada) w_prox = PROX_JOGADA;
                else if (!ctl.fim_rodada) w_prox = PROX_RODADA;
                else                      w_prox = FIM_GANHOU;
            end
            PROX_JOGADA: begin
                ctl.conta_jogada = 1'b1;
                w_prox           = ESPERA;
            end
            PROX_RODADA: begin
                ctl.conta_rodada = 1'b1;
                w_prox           = INICIA_RODADA;
            end
            FIM_GANHOU: begin
                ctl.pronto = 1'b1;
                ctl.ganhou = 1'b1;
                if (ctl.jogar) w_prox = PREPARA;
            end
            FIM_ERROU: begin
                ctl.pronto = 1'b1;
                ctl.perdeu = 1'b1;
                if (ctl.jogar) w_prox = PREPARA;
            end
            FIM_TIMEOUT: begin
                ctl.pronto     = 1'b1;
                ctl.perdeu     = 1'b1;
                ctl.db_timeout = 1'b1;
                if (ctl.jogar) w_prox = PREPARA;
            end
            default: begin
                w_prox = INICIAL;
            end
        endcase
    end

    assign ctl.db_estado = r_estado;

endmodule
